// File: rtl/clint_if.sv
// clint_if: single-outstanding request/response port of the core-local interruptor.
// The master holds creq_* stable until it sees the one-cycle cresp_ready pulse.
interface clint_if;
    logic        creq_valid;
    logic [31:0] creq_addr;
    logic        creq_write;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready;
    logic [63:0] cresp_data;

    modport master (
        output creq_valid, creq_addr, creq_write, creq_strobe, creq_data,
        input  cresp_ready, cresp_data
    );

    modport slave (
        input  creq_valid, creq_addr, creq_write, creq_strobe, creq_data,
        output cresp_ready, cresp_data
    );
endinterface

// File: rtl/clint.sv
// clint: machine timer (mtime/mtimecmp) and software interrupt (msip) behind an MMIO port.
// Define CLINT_PRESCALE_EN to tick mtime once every TICK_DIV cycles instead of every cycle.
module clint #(
    parameter logic [31:0] BASE     = 32'h0200_0000,
    parameter int unsigned TICK_DIV = 16
) (
    input  logic   clk,
    input  logic   reset,
    clint_if.slave bus,
    output logic   trint,
    output logic   swint
);
    localparam logic [31:0] OFF_MSIP     = 32'h0000_0000;
    localparam logic [31:0] OFF_MTIMECMP = 32'h0000_4000;
    localparam logic [31:0] OFF_MTIME    = 32'h0000_BFF8;

    typedef enum logic {IDLE, RESP} state_t;

    if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
        $error("clint: TICK_DIV must be within 1..65535");
    end

    state_t      r_state;
    state_t      w_next_state;
    logic        w_cresp_ready;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [63:0] r_resp_data;
    logic [63:0] w_rd_data;
    logic [31:0] w_word_off;
    logic        w_accept;
    logic        w_sel_msip;
    logic        w_sel_cmp;
    logic        w_sel_time;
    logic        w_wr;
    logic        w_tick;

    function automatic logic [63:0] f_merge(input logic [63:0] old_v,
                                            input logic [63:0] new_v,
                                            input logic [7:0]  strb);
        logic [63:0] res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Offsets below BASE wrap to huge values and decode as unmapped.
    assign w_word_off = (bus.creq_addr - BASE) & ~32'h7;
    assign w_sel_msip = (w_word_off == OFF_MSIP);
    assign w_sel_cmp  = (w_word_off == OFF_MTIMECMP);
    assign w_sel_time = (w_word_off == OFF_MTIME);
    assign w_accept   = (r_state == IDLE) && bus.creq_valid;
    assign w_wr       = w_accept && bus.creq_write;

`ifdef CLINT_PRESCALE_EN
    logic [15:0] r_presc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 16'd1;
    end

    assign w_tick = (r_presc == 16'(TICK_DIV - 1));
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state  = r_state;
        w_cresp_ready = 1'b0;
        case (r_state)
            IDLE: if (bus.creq_valid) w_next_state = RESP;
            RESP: begin
                w_cresp_ready = 1'b1;
                w_next_state  = IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        if (w_sel_msip)      w_rd_data = {63'd0, r_msip};
        else if (w_sel_cmp)  w_rd_data = r_mtimecmp;
        else if (w_sel_time) w_rd_data = r_mtime;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking throughout, so reads and merges see the pre-edge register values.
        if (reset) begin
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_msip      <= 1'b0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) r_resp_data <= w_rd_data;
            // A software write beats a same-edge tick; unwritten bytes hold without incrementing.
            if (w_wr && w_sel_time) r_mtime <= f_merge(r_mtime, bus.creq_data, bus.creq_strobe);
            else if (w_tick)        r_mtime <= r_mtime + 64'd1;
            if (w_wr && w_sel_cmp)  r_mtimecmp <= f_merge(r_mtimecmp, bus.creq_data, bus.creq_strobe);
            if (w_wr && w_sel_msip && bus.creq_strobe[0]) r_msip <= bus.creq_data[0];
        end
    end

    assign bus.cresp_ready = w_cresp_ready;
    assign bus.cresp_data  = r_resp_data;
    assign trint           = (r_mtime >= r_mtimecmp);
    assign swint           = r_msip;
endmodule

// File: tb/tb_clint.sv
// tb_clint: directed bench for clint; expected read data is queued at request time and popped on cresp_ready.
// mtime expectations come from a closed-form tick count (ticks land on edges that are multiples of the tick period).
`timescale 1ns/1ps
module tb_clint;
    localparam logic [31:0] BASE   = 32'h0200_0000;
    localparam logic [31:0] A_MSIP = BASE;
    localparam logic [31:0] A_CMP  = BASE + 32'h0000_4000;
    localparam logic [31:0] A_TIME = BASE + 32'h0000_BFF8;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef CLINT_PRESCALE_EN
    localparam int TDIV = 4;
`else
    localparam int TDIV = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trint;
    logic swint;

    clint_if bif ();

    clint #(.BASE(BASE), .TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif),
        .trint (trint),
        .swint (swint)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt;
    logic [63:0] wr_val;
    int          wr_edge;
    logic [63:0] sb_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // mtime as seen after posedge e (e counted from reset release).
    function automatic logic [63:0] mtime_after(input int e);
        return wr_val + 64'(e / TDIV - wr_edge / TDIV);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [7:0] strb, input logic [63:0] data,
                       input logic [63:0] exp_rd, input logic use_model);
        int          waited;
        int          acc;
        logic [63:0] v;
        @(negedge clk);
        check({tag, ".idle"}, 64'(bif.cresp_ready), 64'd0);
        bif.creq_valid  = 1'b1;
        bif.creq_write  = wr;
        bif.creq_addr   = addr;
        bif.creq_strobe = strb;
        bif.creq_data   = data;
        acc = edge_cnt + 1;
        if (!wr) sb_q.push_back(use_model ? mtime_after(acc - 1) : exp_rd);
        if (wr && addr[31:3] == A_TIME[31:3]) begin
            v = mtime_after(acc - 1);
            for (int i = 0; i < 8; i++) begin
                if (strb[i]) v[8*i +: 8] = data[8*i +: 8];
            end
            wr_val  = v;
            wr_edge = acc;
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bif.cresp_ready !== 1'b1 && waited < 8);
        bif.creq_valid = 1'b0;
        check({tag, ".latency"}, 64'(waited), 64'd1);
        if (!wr) check({tag, ".rdata"}, bif.cresp_data, sb_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        int          n_hi;
        logic [63:0] tmp;
        bif.creq_valid  = 1'b0;
        bif.creq_write  = 1'b0;
        bif.creq_addr   = '0;
        bif.creq_strobe = '0;
        bif.creq_data   = '0;
        wr_val  = '0;
        wr_edge = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.trint", 64'(trint), 64'd0);
        check("rst.swint", 64'(swint), 64'd0);
        check("rst.ready", 64'(bif.cresp_ready), 64'd0);
        check("rst.data", bif.cresp_data, 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle.trint", 64'(trint), 64'd0);
        check("idle.swint", 64'(swint), 64'd0);
        txn("mtime_rd0", 1'b0, A_TIME, 8'h00, 64'd0, 64'd0, 1'b1);

        // Software interrupt bit
        txn("msip_set", 1'b1, A_MSIP, 8'hFF, ONES, 64'd0, 1'b0);
        check("msip_set.swint", 64'(swint), 64'd1);
        txn("msip_rd", 1'b0, A_MSIP, 8'h00, 64'd0, 64'd1, 1'b0);
        txn("msip_clr", 1'b1, A_MSIP, 8'hFF, 64'd0, 64'd0, 1'b0);
        check("msip_clr.swint", 64'(swint), 64'd0);
        txn("msip_nostrb", 1'b1, A_MSIP, 8'hFE, ONES, 64'd0, 1'b0);
        check("msip_nostrb.swint", 64'(swint), 64'd0);

        // Timer compare at 100
        txn("cmp_wr", 1'b1, A_CMP, 8'hFF, 64'd100, 64'd0, 1'b0);
        check("cmp_wr.trint", 64'(trint), 64'd0);
        waited = 0;
        while (trint !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("trint.rise_at_100", mtime_after(edge_cnt), 64'd100);
        txn("cmp_rd_lowbits", 1'b0, A_CMP + 32'd4, 8'h00, 64'd0, 64'd100, 1'b0);
        txn("cmp_max", 1'b1, A_CMP, 8'hFF, ONES, 64'd0, 1'b0);
        check("cmp_max.trint", 64'(trint), 64'd0);

        // Wrap of mtime with mtimecmp at all-ones
        txn("wrap_wr", 1'b1, A_TIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0);
        check("wrap_wr.trint", 64'(trint), 64'd0);
        n_hi = 0;
        for (int i = 0; i < 3 * TDIV + 2; i++) begin
            @(negedge clk);
            check("wrap.trint", 64'(trint), 64'(mtime_after(edge_cnt) == ONES));
            if (trint === 1'b1) n_hi++;
        end
        check("wrap.trint_width", 64'(n_hi), 64'(TDIV));
        txn("wrap_rd", 1'b0, A_TIME, 8'h00, 64'd0, 64'd0, 1'b1);
        check("wrap_rd.small", 64'(bif.cresp_data[63:8]), 64'd0);

        // Partial write on a tick edge where the low word would carry
        txn("part_pre", 1'b1, A_TIME, 8'hFF, 64'h0000_0005_FFFF_FFF0, 64'd0, 1'b0);
        waited = 0;
        forever begin
            tmp = mtime_after(edge_cnt + 1);
            if ((tmp[31:0] == 32'hFFFF_FFFF && (edge_cnt + 2) % TDIV == 0) || waited >= 200) break;
            @(negedge clk);
            waited++;
        end
        txn("part_wr", 1'b1, A_TIME, 8'h0F, 64'hDEAD_BEEF_1234_5678, 64'd0, 1'b0);
        txn("part_rd", 1'b0, A_TIME, 8'h00, 64'd0, 64'd0, 1'b1);
        check("part_rd.hi", 64'(bif.cresp_data[63:32]), 64'h5);

        // Unmapped addresses
        txn("unmap_wr", 1'b1, BASE + 32'h0100, 8'hFF, ONES, 64'd0, 1'b0);
        txn("unmap_rd", 1'b0, BASE + 32'h0100, 8'h00, 64'd0, 64'd0, 1'b0);
        txn("below_rd", 1'b0, 32'h0100_0000, 8'h00, 64'd0, 64'd0, 1'b0);
        txn("msip_after_unmap", 1'b0, A_MSIP, 8'h00, 64'd0, 64'd0, 1'b0);
        check("unmap.swint", 64'(swint), 64'd0);

        // Reset in the middle of a read
        @(negedge clk);
        bif.creq_valid = 1'b1;
        bif.creq_write = 1'b0;
        bif.creq_addr  = A_TIME;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rstmid.ready", 64'(bif.cresp_ready), 64'd0);
        @(negedge clk);
        bif.creq_valid = 1'b0;
        sb_q.delete();
        wr_val  = '0;
        wr_edge = 0;
        check("rstmid.data", bif.cresp_data, 64'd0);
        check("rstmid.trint", 64'(trint), 64'd0);
        check("rstmid.swint", 64'(swint), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid.no_late_ready", 64'(bif.cresp_ready), 64'd0);
        txn("rstmid_rd", 1'b0, A_TIME, 8'h00, 64'd0, 64'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
